ir_fetch_buffer: RTL and testbench



---
 rtl/ir_fetch_buffer.sv | 106 ++++++++++
 tb/tb_ir_fetch_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_buffer.sv
// Instruction fetch buffer: DEPTH-entry FIFO of fetched words with MIPS field decode of the head.
// Optional macro IR_PC_TRACK_EN adds per-entry PC storage (in_pc / out_pc).
module ir_fetch_buffer #(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      read_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      instruction_word,
   output logic [5:0]       instruction_opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [15:0]      alu_immediate,
   output logic [5:0]       func_code,
`ifdef IR_PC_TRACK_EN
   input  logic [31:0]      in_pc,
   output logic [31:0]      out_pc,
`endif
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]      word_mem_q [DEPTH];
   logic [31:0]      head_word;
   logic             push, pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Handshake decisions use registered occupancy only; flush discards both sides.
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = ptr_next(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is data only and carries no reset.
   always_ff @(posedge clk) begin
      if (push && !reset) word_mem_q[wr_ptr_q] <= read_data;
   end

   assign head_word          = out_valid ? word_mem_q[rd_ptr_q] : '0;
   assign instruction_word   = head_word;
   assign instruction_opcode = head_word[31:26];
   assign rs                 = head_word[25:21];
   assign rt                 = head_word[20:16];
   assign rd                 = head_word[15:11];
   assign shamt              = head_word[10:6];
   assign alu_immediate      = head_word[15:0];
   assign func_code          = head_word[5:0];
   assign count              = count_q;

`ifdef IR_PC_TRACK_EN
   logic [31:0] pc_mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (push && !reset) pc_mem_q[wr_ptr_q] <= in_pc;
   end

   assign out_pc = out_valid ? pc_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_ir_fetch_buffer.sv
// Bench for ir_fetch_buffer: directed plan steps plus random traffic against a queue model.
module tb_ir_fetch_buffer;

   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, out_ready;
   logic [31:0]      read_data;
   logic             in_ready, out_valid;
   logic [31:0]      instruction_word;
   logic [5:0]       instruction_opcode, func_code;
   logic [4:0]       rs, rt, rd, shamt;
   logic [15:0]      alu_immediate;
   logic [CNT_W-1:0] count;
`ifdef IR_PC_TRACK_EN
   logic [31:0]      in_pc, out_pc;
`endif

   int total = 0;
   int bad   = 0;

   // Model: each entry holds {pc, word}; the head is q[0].
   logic [63:0] q [$];

   always #5 clk = ~clk;

   ir_fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .flush              (flush),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .read_data          (read_data),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .instruction_word   (instruction_word),
      .instruction_opcode (instruction_opcode),
      .rs                 (rs),
      .rt                 (rt),
      .rd                 (rd),
      .shamt              (shamt),
      .alu_immediate      (alu_immediate),
      .func_code          (func_code),
`ifdef IR_PC_TRACK_EN
      .in_pc              (in_pc),
      .out_pc             (out_pc),
`endif
      .count              (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] h;
      logic [31:0] hp;
      h  = (q.size() != 0) ? q[0][31:0]  : 32'h0;
      hp = (q.size() != 0) ? q[0][63:32] : 32'h0;
      chk("count",     32'(count),     32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
      chk("word",      instruction_word, h);
      chk("opcode",    32'(instruction_opcode), 32'(h >> 26));
      chk("rs",        32'(rs),    (h >> 21) & 32'h1F);
      chk("rt",        32'(rt),    (h >> 16) & 32'h1F);
      chk("rd",        32'(rd),    (h >> 11) & 32'h1F);
      chk("shamt",     32'(shamt), (h >> 6)  & 32'h1F);
      chk("imm",       32'(alu_immediate), h & 32'hFFFF);
      chk("func",      32'(func_code),     h & 32'h3F);
`ifdef IR_PC_TRACK_EN
      chk("out_pc",    out_pc, hp);
`else
      if (hp != hp) chk("pc_unused", 32'h0, 32'h1);
`endif
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the model, then check.
   task automatic step(input logic iv, input logic [31:0] d, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rst);
      logic do_push, do_pop;
      in_valid  = iv;
      read_data = d;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
`ifdef IR_PC_TRACK_EN
      in_pc     = pc;
`endif
      @(posedge clk);
      if (rst || fl) begin
         q.delete();
      end else begin
         do_push = iv && (q.size() < DEPTH);
         do_pop  = ordy && (q.size() != 0);
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back({pc, d});
      end
      #1;
      check_model();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; read_data = '0;
`ifdef IR_PC_TRACK_EN
      in_pc = '0;
`endif
      #2;

      // Reset, then idle
      step(0, 32'h0, 32'h0, 0, 0, 1);
      step(0, 32'h0, 32'h0, 0, 0, 1);
      step(0, 32'hDEADBEEF, 32'h0, 1, 0, 0);
      chk("idle_word", instruction_word, 32'h0);
      chk("idle_cnt",  32'(count), 32'd0);

      // Single R-type push: add $8,$9,$10
      step(1, 32'h012A4020, 32'h0, 0, 0, 0);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_rs",    32'(rs), 32'd9);
      chk("add_rt",    32'(rt), 32'd10);
      chk("add_rd",    32'(rd), 32'd8);
      chk("add_func",  32'(func_code), 32'h20);
      chk("add_cnt",   32'(count), 32'd1);

      // Fill, overflow drop, drain
      step(0, 32'h0, 32'h0, 0, 0, 1);
      step(1, 32'h8D090004, 32'h0, 0, 0, 0);
      step(1, 32'h21290001, 32'h0, 0, 0, 0);
      chk("full_cnt",   32'(count), 32'd2);
      chk("full_rdy",   32'(in_ready), 32'd0);
      step(1, 32'hFFFFFFFF, 32'h0, 0, 0, 0);
      chk("lw_word",    instruction_word, 32'h8D090004);
      chk("lw_opcode",  32'(instruction_opcode), 32'h23);
      chk("lw_imm",     32'(alu_immediate), 32'h0004);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      chk("addi_word",  instruction_word, 32'h21290001);
      step(1, 32'h55555555, 32'h0, 1, 0, 0);
      chk("push_pop_cnt", 32'(count), 32'd1);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      chk("drain_cnt",  32'(count), 32'd0);
      chk("drain_word", instruction_word, 32'h0);

      // Streaming with both sides always ready
      for (int k = 0; k < 8; k++) begin
         step(1, 32'hA0000000 + 32'(k), 32'h0, 1, 0, 0);
         chk("stream_cnt",  32'(count), 32'd1);
         chk("stream_word", instruction_word, 32'hA0000000 + 32'(k));
      end

      // Flush while full with a concurrent push and pop
      step(0, 32'h0, 32'h0, 0, 0, 1);
      step(1, 32'h00000001, 32'h0, 0, 0, 0);
      step(1, 32'h00000002, 32'h0, 0, 0, 0);
      step(1, 32'h11223344, 32'h0, 1, 1, 0);
      chk("flush_cnt",   32'(count), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(0, 32'h0, 32'h0, 1, 0, 0);
         chk("flush_absent", 32'(instruction_word == 32'h11223344), 32'd0);
      end

`ifdef IR_PC_TRACK_EN
      step(1, 32'h00000020, 32'hBFC00000, 0, 0, 0);
      step(1, 32'h00000021, 32'hBFC00004, 0, 0, 0);
      chk("pc_head0", out_pc, 32'hBFC00000);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      chk("pc_head1", out_pc, 32'hBFC00004);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      chk("pc_empty", out_pc, 32'h0);
`endif

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), $urandom(), $urandom(),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 99) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
